// File: rtl/spi_block_reader.sv
// spi_block_reader: receives SPI data-response blocks and bursts their payload to an MCB write port; optional CRC16 check under SPI_READER_CRC16_EN
module spi_block_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int BURST_WORDS   = 32,
  parameter int TOKEN_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        calib_done,
  input  logic        sclk_posedge,
  input  logic        sclk_negedge,
  input  logic        in,
  input  logic        en,
  input  logic [29:0] start_addr,
  input  logic [7:0]  n_blocks,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  input  logic        mem_wr_empty,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error
);
  localparam int BW = $clog2(BLOCK_BYTES + 1);
  localparam int WW = $clog2(BURST_WORDS + 1);
  localparam int TW = $clog2(TOKEN_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BLOCK_BYTES - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(BURST_WORDS - 1);
  localparam logic [TW-1:0] LAST_TMO = TW'(TOKEN_TIMEOUT - 1);
  localparam logic [29:0] ADDR_STEP = 30'(4 * BURST_WORDS);
  typedef enum logic [2:0] {IDLE, TOKEN, DATA, CRC, FLUSH, ERROR} state_t;
  state_t state;
  logic [2:0] bit_cnt;
  logic [7:0] cur_byte;
  logic byte_valid;
  logic [BW-1:0] byte_cnt;
  logic [WW-1:0] word_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [7:0] blk_left;
  logic [29:0] addr;
  logic cmd_due;
  logic crc_cnt;
  logic word_done, burst_done, tok_err, tmo_err, crc_bad, ovf, mcb_err;
  logic [2:0] err_nxt;
  assign busy = state != IDLE;
  assign done = state == IDLE && !en;
  assign mem_cmd_instr = 3'b000;
  assign mem_cmd_bl = 6'(BURST_WORDS - 1);
  assign mem_wr_mask = 4'b0000;
  assign word_done = byte_valid && state == DATA && byte_cnt[1:0] == 2'd3;
  assign burst_done = word_done && word_cnt == LAST_WORD;
  assign tok_err = state == TOKEN && byte_valid && cur_byte[7:5] == 3'd0;
  assign tmo_err = state == TOKEN && byte_valid && cur_byte != 8'hFE && cur_byte[7:5] != 3'd0 && tmo_cnt == LAST_TMO;
  assign ovf = (word_done && mem_wr_full) || (cmd_due && mem_cmd_full);
  assign mcb_err = calib_done && (mem_wr_error || mem_wr_underrun) && state != IDLE && state != ERROR;
  assign err_nxt = tok_err ? 3'd1 : tmo_err ? 3'd2 : crc_bad ? 3'd3 : ovf ? 3'd4 : mcb_err ? 3'd5 : 3'd0;
`ifdef SPI_READER_CRC16_EN
  logic [15:0] crc;
  logic [7:0] crc_hi;
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction
  assign crc_bad = state == CRC && byte_valid && crc_cnt && {crc_hi, cur_byte} != crc;
  // running CRC over the payload, restarted while hunting for each start token
  always_ff @(posedge clk) begin
    if (rst) begin
      crc <= 16'h0000;
      crc_hi <= 8'h00;
    end else begin
      crc <= state == TOKEN ? 16'h0000 : (state == DATA && byte_valid) ? crc_byte(crc, cur_byte) : crc;
      crc_hi <= (state == CRC && byte_valid && !crc_cnt) ? cur_byte : crc_hi;
    end
  end
`else
  assign crc_bad = 1'b0;
`endif
  // bit assembly, block sequencing and MCB command/data generation
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bit_cnt <= 3'd7;
      cur_byte <= 8'hFF;
      byte_valid <= 1'b0;
      error <= 1'b0;
      err_code <= 3'd0;
      mem_cmd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wr_data <= 32'd0;
      mem_cmd_byte_addr <= 30'd0;
      byte_cnt <= '0;
      word_cnt <= '0;
      tmo_cnt <= '0;
      blk_left <= 8'd0;
      addr <= 30'd0;
      cmd_due <= 1'b0;
      crc_cnt <= 1'b0;
    end else begin
      if (sclk_posedge) cur_byte[bit_cnt] <= in;
      if (sclk_negedge) bit_cnt <= bit_cnt - 3'd1;
      byte_valid <= sclk_posedge && bit_cnt == 3'd0;
      mem_wr_en <= 1'b0;
      mem_cmd_en <= 1'b0;
      if (err_nxt != 3'd0) begin
        state <= ERROR;
        error <= 1'b1;
        err_code <= err_nxt;
        cmd_due <= 1'b0;
      end else begin
        if (cmd_due) begin
          cmd_due <= 1'b0;
          mem_cmd_en <= 1'b1;
          mem_cmd_byte_addr <= addr;
          addr <= addr + ADDR_STEP;
        end
        case (state)
          IDLE: if (en) begin
            addr <= start_addr & ~30'h3;
            blk_left <= n_blocks == 8'd0 ? 8'd1 : n_blocks;
            tmo_cnt <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            state <= TOKEN;
          end
          TOKEN: if (byte_valid) begin
            if (cur_byte == 8'hFE) begin
              state <= DATA;
              byte_cnt <= '0;
              word_cnt <= '0;
            end else tmo_cnt <= tmo_cnt + TW'(1);
          end
          DATA: if (byte_valid) begin
            mem_wr_data <= {mem_wr_data[23:0], cur_byte};
            byte_cnt <= byte_cnt + BW'(1);
            if (word_done) begin
              mem_wr_en <= 1'b1;
              word_cnt <= burst_done ? '0 : word_cnt + WW'(1);
              cmd_due <= burst_done;
            end
            if (byte_cnt == LAST_BYTE) begin
              state <= CRC;
              crc_cnt <= 1'b0;
            end
          end
          CRC: if (byte_valid) begin
            crc_cnt <= 1'b1;
            if (crc_cnt) begin
              state <= blk_left > 8'd1 ? TOKEN : FLUSH;
              blk_left <= blk_left - 8'd1;
              tmo_cnt <= '0;
            end
          end
          FLUSH: if (mem_wr_empty) state <= IDLE;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_block_reader.sv
// tb_spi_block_reader: directed self-checking bench for spi_block_reader (TOKEN_TIMEOUT=16)
module tb_spi_block_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic calib_done = 1'b1;
  logic sclk_posedge = 1'b0;
  logic sclk_negedge = 1'b0;
  logic in = 1'b1;
  logic en = 1'b0;
  logic [29:0] start_addr = 30'd0;
  logic [7:0] n_blocks = 8'd1;
  logic busy, done, error, mem_cmd_en, mem_wr_en;
  logic [2:0] err_code, mem_cmd_instr;
  logic [5:0] mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic [3:0] mem_wr_mask;
  logic [31:0] mem_wr_data;
  logic mem_cmd_full = 1'b0;
  logic mem_wr_full = 1'b0;
  logic mem_wr_empty = 1'b0;
  logic mem_wr_underrun = 1'b0;
  logic mem_wr_error = 1'b0;
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int cmd_cnt = 0;
  int busy_drop = 0;
  logic clr = 1'b0;
  logic track = 1'b0;
  logic [31:0] wr_log [0:511];
  logic [29:0] cmd_log [0:15];

  spi_block_reader #(.BLOCK_BYTES(512), .BURST_WORDS(32), .TOKEN_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .calib_done(calib_done), .sclk_posedge(sclk_posedge),
    .sclk_negedge(sclk_negedge), .in(in), .en(en), .start_addr(start_addr), .n_blocks(n_blocks),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .mem_cmd_en(mem_cmd_en),
    .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl), .mem_cmd_byte_addr(mem_cmd_byte_addr),
    .mem_cmd_full(mem_cmd_full), .mem_wr_en(mem_wr_en), .mem_wr_mask(mem_wr_mask),
    .mem_wr_data(mem_wr_data), .mem_wr_full(mem_wr_full), .mem_wr_empty(mem_wr_empty),
    .mem_wr_underrun(mem_wr_underrun), .mem_wr_error(mem_wr_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (clr) begin
      wr_cnt = 0;
      cmd_cnt = 0;
      busy_drop = 0;
    end else begin
      if (mem_wr_en) begin
        if (wr_cnt < 512) wr_log[wr_cnt] = mem_wr_data;
        wr_cnt++;
      end
      if (mem_cmd_en) begin
        if (cmd_cnt < 16) cmd_log[cmd_cnt] = mem_cmd_byte_addr;
        cmd_cnt++;
      end
      if (track && !busy) busy_drop++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[7-i];
      r = r << 1;
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    clr = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr = 1'b0;
  endtask

  task automatic start(input logic [29:0] a, input logic [7:0] n);
    @(negedge clk);
    start_addr = a;
    n_blocks = n;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      in = b[i];
      sclk_posedge = 1'b1;
      sclk_negedge = 1'b0;
      @(negedge clk);
      sclk_posedge = 1'b0;
      sclk_negedge = 1'b1;
    end
    @(negedge clk);
    sclk_negedge = 1'b0;
  endtask

  task automatic send_block(input bit zeros, input bit own_crc, input logic [15:0] crc_in);
    logic [15:0] c;
    logic [7:0] d;
    c = 16'h0000;
    send_byte(8'hFE);
    for (int i = 0; i < 512; i++) begin
      d = zeros ? 8'h00 : 8'(i);
      c = crc_upd(c, d);
      send_byte(d);
    end
    if (!own_crc) c = crc_in;
    send_byte(c[15:8]);
    send_byte(c[7:0]);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_wdata", mem_wr_data, 32'd0);
    chk("rst_caddr", 32'(mem_cmd_byte_addr), 32'd0);
    chk("const_instr", 32'(mem_cmd_instr), 32'd0);
    chk("const_bl", 32'(mem_cmd_bl), 32'd31);
    chk("const_mask", 32'(mem_wr_mask), 32'd0);

    // single block, low address bits dropped, flush waits for empty write FIFO
    mem_wr_empty = 1'b0;
    start(30'h102, 8'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    send_byte(8'hFF);
    send_block(1'b0, 1'b1, 16'h0000);
    repeat (3) @(negedge clk);
    chk("t1_wr_cnt", wr_cnt, 32'd128);
    chk("t1_first", wr_log[0], 32'h00010203);
    chk("t1_last", wr_log[127], 32'hFCFDFEFF);
    chk("t1_cmd_cnt", cmd_cnt, 32'd4);
    chk("t1_cmd0", 32'(cmd_log[0]), 32'h100);
    chk("t1_cmd1", 32'(cmd_log[1]), 32'h180);
    chk("t1_cmd2", 32'(cmd_log[2]), 32'h200);
    chk("t1_cmd3", 32'(cmd_log[3]), 32'h280);
    chk("t1_flush_busy", 32'(busy), 32'd1);
    mem_wr_empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);

    // three blocks with address wrap past 2^30
    do_reset();
    start(30'h3FFFFF00, 8'd3);
    track = 1'b1;
    send_block(1'b0, 1'b1, 16'h0000);
    send_byte(8'hFF);
    send_block(1'b0, 1'b1, 16'h0000);
    send_block(1'b0, 1'b1, 16'h0000);
    track = 1'b0;
    repeat (3) @(negedge clk);
    chk("t2_busy_drop", busy_drop, 32'd0);
    chk("t2_wr_cnt", wr_cnt, 32'd384);
    chk("t2_cmd_cnt", cmd_cnt, 32'd12);
    chk("t2_cmd1", 32'(cmd_log[1]), 32'h3FFFFF80);
    chk("t2_cmd2", 32'(cmd_log[2]), 32'h0);
    chk("t2_cmd11", 32'(cmd_log[11]), 32'h480);
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_error", 32'(error), 32'd0);

    // error token
    do_reset();
    start(30'h0, 8'd1);
    repeat (3) send_byte(8'hFF);
    send_byte(8'h05);
    @(negedge clk);
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_code", 32'(err_code), 32'd1);
    chk("t3_pulses", wr_cnt + cmd_cnt, 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);

    // MCB status ignored before calibration, then token timeout
    do_reset();
    start(30'h0, 8'd1);
    calib_done = 1'b0;
    mem_wr_underrun = 1'b1;
    repeat (3) @(negedge clk);
    mem_wr_underrun = 1'b0;
    calib_done = 1'b1;
    chk("t4_nocalib", 32'(error), 32'd0);
    repeat (15) send_byte(8'hFF);
    @(negedge clk);
    chk("t4_before", 32'(error), 32'd0);
    send_byte(8'hFF);
    @(negedge clk);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_code", 32'(err_code), 32'd2);

    // write FIFO full on fifth word, later MCB error must not overwrite the code
    do_reset();
    start(30'h0, 8'd1);
    send_byte(8'hFE);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    mem_wr_full = 1'b1;
    for (int i = 16; i < 20; i++) send_byte(8'(i));
    mem_wr_full = 1'b0;
    @(negedge clk);
    chk("t5_code", 32'(err_code), 32'd4);
    chk("t5_wr_cnt", wr_cnt, 32'd4);
    mem_wr_error = 1'b1;
    repeat (2) @(negedge clk);
    mem_wr_error = 1'b0;
    chk("t5_sticky", 32'(err_code), 32'd4);
    chk("t5_error", 32'(error), 32'd1);

    // MCB write error during token hunt
    do_reset();
    start(30'h0, 8'd1);
    mem_wr_error = 1'b1;
    @(negedge clk);
    mem_wr_error = 1'b0;
    @(negedge clk);
    chk("t6_code", 32'(err_code), 32'd5);

    // zero payload with CRC 0x0000, then with CRC 0x1234
    do_reset();
    start(30'h0, 8'd1);
    send_block(1'b1, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);
    chk("t7_pass_err", 32'(error), 32'd0);
    chk("t7_pass_done", 32'(done), 32'd1);
    do_reset();
    start(30'h0, 8'd1);
    send_block(1'b1, 1'b0, 16'h1234);
    repeat (2) @(negedge clk);
`ifdef SPI_READER_CRC16_EN
    chk("t7_bad_code", 32'(err_code), 32'd3);
    chk("t7_bad_err", 32'(error), 32'd1);
`else
    chk("t7_nocrc_code", 32'(err_code), 32'd0);
    chk("t7_nocrc_done", 32'(done), 32'd1);
`endif
    do_reset();
    @(negedge clk);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_err", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
